axi3_sram_slave: RTL and testbench
==================================

AXI3_SRAM_SLAVE -- requirements
Module: axi3_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, giving the memory depth as 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter RD_LAT, default 1, giving the cycles from AR handshake to the first R beat (range 1..7).
REQ-003 SHALL have the following ports, clock and reset first:
aclk  in  1  single clock; all logic on its rising edge.
aresetn  in  1  asynchronous active-low reset.
arid  in  4  read transaction ID.
araddr  in  32  read byte address; bits [1:0] ignored.
arlen  in  4  read beats minus 1.
arburst  in  2  read burst type.
arvalid  in  1  AR valid.
arready  out  1  AR ready.
rid  out  4  returned read ID.
rdata  out  32  read data.
rresp  out  2  read response.
rlast  out  1  last read beat.
rvalid  out  1  R valid.
rready  in  1  R ready.
awid  in  4  write transaction ID.
awaddr  in  32  write byte address; bits [1:0] ignored.
awlen  in  4  write beats minus 1.
awburst  in  2  write burst type.
awvalid  in  1  AW valid.
awready  out  1  AW ready.
wid  in  4  write data ID; ignored.
wdata  in  32  write data.
wstrb  in  4  byte lane enables.
wlast  in  1  last write beat; ignored (beat count governs).
wvalid  in  1  W valid.
wready  out  1  W ready.
bid  out  4  write response ID.
bresp  out  2  write response.
bvalid  out  1  B valid.
bready  in  1  B ready.

Function
REQ-004 SHALL implement independent read and write FSMs, each with one transaction outstanding; a read and a write SHALL be able to proceed in the same cycle.
REQ-005 Read FSM states: IDLE (arready=1) -> WAIT on arvalid&arready (latch id, word address, len, burst; load latency counter with RD_LAT-1) -> DATA once the counter reaches 0 -> IDLE on the rvalid&rready beat with rlast=1.
REQ-006 In DATA, rvalid SHALL be held at 1; rdata, rid and rlast SHALL be held stable while rready=0; the beat counter and address SHALL advance only on an rvalid&rready handshake.
REQ-007 Write FSM states: IDLE (awready=1) -> DATA on the AW handshake (wready=1) -> RESP after the (awlen+1)th W handshake (bvalid=1, bid=latched awid) -> IDLE on bvalid&bready.
REQ-008 Each W handshake SHALL write only the bytes whose wstrb bit is 1, at word index addr[DEPTH_LOG2+1:2].
REQ-009 Address increment: INCR (01) and WRAP (10) SHALL add 1 word per beat; FIXED (00) SHALL hold the address. An incrementing address that passes the top of the memory SHALL wrap modulo 2^DEPTH_LOG2.
REQ-010 rresp and bresp SHALL be 00 (OKAY) for burst types 00, 01 and 10. For burst type 11, rresp/bresp SHALL be 10 (SLVERR) for every beat, and the write SHALL still consume its W beats without modifying memory.
REQ-011 A read of a word written by a W handshake in the same or an earlier cycle SHALL return the new data, provided the R beat is presented at least one cycle after that W handshake.
REQ-012 A W beat arriving before its AW handshake SHALL be stalled (wready=0 outside DATA).

Reset
REQ-013 While aresetn=0: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rid=0, bid=0, rresp=0, bresp=0, rdata=0; both FSMs SHALL be in IDLE.
REQ-014 Deasserting aresetn mid-burst SHALL abandon the transaction with no further beats issued. Memory contents SHALL be retained across reset and SHALL be undefined at power-up.

Verification
REQ-015 Single write then read: AW addr=0x100, len=0, W 0xDEADBEEF with wstrb=F, bready=1 -> bresp=00, bid=awid; AR addr=0x100 -> rdata=0xDEADBEEF, rlast=1, rresp=00.
REQ-016 INCR burst: write a 4-beat burst at 0x0 with data 1..4, then read it back with len=3 and rready toggling every cycle -> data 1,2,3,4 in order, stable while stalled, rlast on beat 4 only.
REQ-017 Partial strobe: write 0xAABBCCDD with wstrb=F, then 0x11223344 with wstrb=0101 -> read returns 0xAA22CC44.
REQ-018 FIXED and wrap-around: FIXED 3-beat write to one word -> last beat's data persists; INCR read at the top word with len=1 -> second beat returns word 0.
REQ-019 Concurrency/reset: an AR and an AW handshake in the same cycle both complete correctly; asserting aresetn=0 during the second R beat -> rvalid=0 immediately and arready=1 one cycle after release.

Source files
------------

// File: rtl/axi3_sram_slave.sv
// AXI3 slave fronting a single-port-per-channel 32-bit SRAM array.
// Independent read and write engines, one outstanding transaction each.
module axi3_sram_slave #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] RD_IDLE = 2'd0, RD_WAIT = 2'd1, RD_DATA = 2'd2;
    localparam logic [1:0] WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'b00, BURST_RSVD = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

    logic [31:0] mem [DEPTH];

    logic [1:0]       rd_state, rd_state_d, rd_burst, rd_burst_d;
    logic [AW-1:0]    rd_addr, rd_addr_d, rd_addr_inc, rd_mem_addr;
    logic [3:0]       rd_len, rd_len_d, rd_beat, rd_beat_d, rid_d;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_d;
    logic [1:0]       rresp_d;
    logic             arready_d, rvalid_d, rlast_d, rd_load;

    logic [1:0]       wr_state, wr_state_d, wr_burst, wr_burst_d, bresp_d;
    logic [AW-1:0]    wr_addr, wr_addr_d, wr_addr_inc;
    logic [3:0]       wr_len, wr_len_d, wr_beat, wr_beat_d, bid_d;
    logic             awready_d, wready_d, bvalid_d, mem_we;

    logic unused_ok;
    assign unused_ok = ^{wid, wlast, araddr, awaddr};

    // Read engine: next-state and next-output decode
    always_comb begin
        rd_state_d  = rd_state;
        rd_addr_d   = rd_addr;
        rd_len_d    = rd_len;
        rd_beat_d   = rd_beat;
        rd_burst_d  = rd_burst;
        rd_cnt_d    = rd_cnt;
        arready_d   = arready;
        rvalid_d    = rvalid;
        rlast_d     = rlast;
        rid_d       = rid;
        rresp_d     = rresp;
        rd_load     = 1'b0;
        rd_addr_inc = (rd_burst == BURST_FIXED) ? rd_addr : rd_addr + AW'(1);
        rd_mem_addr = rd_addr;
        case (rd_state)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready) begin
                    arready_d  = 1'b0;
                    rd_state_d = RD_WAIT;
                    rid_d      = arid;
                    rd_addr_d  = araddr[AW+1:2];
                    rd_len_d   = arlen;
                    rd_burst_d = arburst;
                    rd_beat_d  = 4'd0;
                    rd_cnt_d   = CNT_W'(RD_LAT - 1);
                end
            end
            RD_WAIT: begin
                if (rd_cnt == '0) begin
                    rd_state_d = RD_DATA;
                    rd_load    = 1'b1;
                    rvalid_d   = 1'b1;
                    rlast_d    = (rd_len == 4'd0);
                    rresp_d    = (rd_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    rd_cnt_d = rd_cnt - CNT_W'(1);
                end
            end
            RD_DATA: begin
                if (rready) begin
                    if (rlast) begin
                        rd_state_d = RD_IDLE;
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                        arready_d  = 1'b1;
                    end else begin
                        rd_load     = 1'b1;
                        rd_mem_addr = rd_addr_inc;
                        rd_addr_d   = rd_addr_inc;
                        rd_beat_d   = rd_beat + 4'd1;
                        rlast_d     = ((rd_beat + 4'd1) == rd_len);
                    end
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
                rvalid_d   = 1'b0;
                rlast_d    = 1'b0;
            end
        endcase
    end

    // Write engine: next-state and next-output decode
    always_comb begin
        wr_state_d  = wr_state;
        wr_addr_d   = wr_addr;
        wr_len_d    = wr_len;
        wr_beat_d   = wr_beat;
        wr_burst_d  = wr_burst;
        awready_d   = awready;
        wready_d    = wready;
        bvalid_d    = bvalid;
        bid_d       = bid;
        bresp_d     = bresp;
        mem_we      = 1'b0;
        wr_addr_inc = (wr_burst == BURST_FIXED) ? wr_addr : wr_addr + AW'(1);
        case (wr_state)
            WR_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready) begin
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    wr_state_d = WR_DATA;
                    bid_d      = awid;
                    wr_addr_d  = awaddr[AW+1:2];
                    wr_len_d   = awlen;
                    wr_burst_d = awburst;
                    wr_beat_d  = 4'd0;
                end
            end
            WR_DATA: begin
                if (wvalid && wready) begin
                    mem_we    = (wr_burst != BURST_RSVD);
                    wr_addr_d = wr_addr_inc;
                    wr_beat_d = wr_beat + 4'd1;
                    if (wr_beat == wr_len) begin
                        wr_state_d = WR_RESP;
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        bresp_d    = (wr_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            WR_RESP: begin
                if (bvalid && bready) begin
                    wr_state_d = WR_IDLE;
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
                wready_d   = 1'b0;
                bvalid_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rresp    <= '0;
            rdata    <= '0;
            wr_state <= WR_IDLE;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_beat  <= '0;
            wr_burst <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= '0;
        end else begin
            rd_state <= rd_state_d;
            rd_addr  <= rd_addr_d;
            rd_len   <= rd_len_d;
            rd_beat  <= rd_beat_d;
            rd_burst <= rd_burst_d;
            rd_cnt   <= rd_cnt_d;
            arready  <= arready_d;
            rvalid   <= rvalid_d;
            rlast    <= rlast_d;
            rid      <= rid_d;
            rresp    <= rresp_d;
            if (rd_load) rdata <= mem[rd_mem_addr];
            wr_state <= wr_state_d;
            wr_addr  <= wr_addr_d;
            wr_len   <= wr_len_d;
            wr_beat  <= wr_beat_d;
            wr_burst <= wr_burst_d;
            awready  <= awready_d;
            wready   <= wready_d;
            bvalid   <= bvalid_d;
            bid      <= bid_d;
            bresp    <= bresp_d;
        end
    end

    // Storage has no reset so contents survive aresetn
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[wr_addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi3_sram_slave.sv
// Self-checking bench for axi3_sram_slave: vector table of single-beat
// write/read pairs plus hand-built burst, wrap, concurrency and reset cases.
module tb_axi3_sram_slave;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic        aclk, aresetn;
    logic [3:0]  arid, arlen, rid, awid, awlen, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [1:0]  arburst, rresp, awburst, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi3_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    rbeat_t      exp_q [$];
    vec_t        vecs [6];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] ed [16];
    int          tests = 0;
    int          failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [1:0] burst,
                               input logic [1:0] exp_resp);
        int n;
        @(posedge aclk); #1;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        n = 0; @(negedge aclk);
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        if (!awready) begin check("aw_timeout", 32'(awready), 32'd1); awvalid = 1'b0; return; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == int'(len));
            n = 0; @(negedge aclk);
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            if (!wready) begin check("w_timeout", 32'(wready), 32'd1); wvalid = 1'b0; return; end
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0; @(negedge aclk);
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'(exp_resp));
        check("bid", 32'(bid), 32'(id));
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // Expected beats go to the scoreboard before AR; popped as R beats are accepted
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] burst,
                              input logic [1:0] resp, input bit toggle);
        int n;
        bit done, have_held;
        rbeat_t e, held;
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back('{id: id, data: ed[i], resp: resp, last: (i == int'(len))});
        @(posedge aclk); #1;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        n = 0; @(negedge aclk);
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        if (!arready) begin check("ar_timeout", 32'(arready), 32'd1); arvalid = 1'b0; exp_q.delete(); return; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        rready = !toggle;
        done = 1'b0; have_held = 1'b0; held = '0; n = 0;
        while (!done && n < 200) begin
            @(negedge aclk);
            if (rvalid) begin
                if (have_held) begin
                    check("r_stable_data", rdata, held.data);
                    check("r_stable_last", 32'(rlast), 32'(held.last));
                    check("r_stable_id", 32'(rid), 32'(held.id));
                end
                if (rready) begin
                    have_held = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("r_unexpected_beat", 32'(rvalid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", rdata, e.data);
                        check("rresp", 32'(rresp), 32'(e.resp));
                        check("rlast", 32'(rlast), 32'(e.last));
                        check("rid", 32'(rid), 32'(e.id));
                        done = e.last;
                    end
                end else begin
                    held = '{id: rid, data: rdata, resp: rresp, last: rlast};
                    have_held = 1'b1;
                end
            end
            @(posedge aclk); #1;
            if (toggle) rready = ~rready;
            n++;
        end
        rready = 1'b0;
        if (!done) begin check("r_timeout", 32'(done), 32'd1); exp_q.delete(); end
    endtask

    initial begin
        int n;
        vecs[0] = '{addr: 32'h100,  wdata: 32'hDEADBEEF, wstrb: 4'hF, exp: 32'hDEADBEEF};
        vecs[1] = '{addr: 32'h200,  wdata: 32'hAABBCCDD, wstrb: 4'hF, exp: 32'hAABBCCDD};
        vecs[2] = '{addr: 32'h200,  wdata: 32'h11223344, wstrb: 4'h5, exp: 32'hAA22CC44};
        vecs[3] = '{addr: 32'h200,  wdata: 32'h00000000, wstrb: 4'h8, exp: 32'h0022CC44};
        vecs[4] = '{addr: 32'h3FFC, wdata: 32'hCAFEF00D, wstrb: 4'hF, exp: 32'hCAFEF00D};
        vecs[5] = '{addr: 32'h101,  wdata: 32'h00000011, wstrb: 4'h1, exp: 32'hDEADBE11};

        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = INCR; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = INCR; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; ed[i] = '0; end

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rid_bid", 32'({rid, bid, rresp, bresp, rlast}), 32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_awready", 32'(awready), 32'd1);

        // Table: single-beat write then read-back
        for (int i = 0; i < 6; i++) begin
            wd[0] = vecs[i].wdata; ws[0] = vecs[i].wstrb; ed[0] = vecs[i].exp;
            write_burst(4'(i), vecs[i].addr, 4'd0, INCR, OKAY);
            read_burst(4'(i + 8), vecs[i].addr, 4'd0, INCR, OKAY, 1'b0);
        end

        // 4-beat INCR burst, read back with rready toggling
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; ed[i] = 32'(i + 1); end
        write_burst(4'd3, 32'h0, 4'd3, INCR, OKAY);
        read_burst(4'd7, 32'h0, 4'd3, INCR, OKAY, 1'b1);

        // FIXED burst: final beat persists
        wd[0] = 32'h0000000A; wd[1] = 32'h0000000B; wd[2] = 32'h0000000C;
        write_burst(4'd2, 32'h300, 4'd2, FIXED, OKAY);
        ed[0] = 32'h0000000C;
        read_burst(4'd2, 32'h300, 4'd0, INCR, OKAY, 1'b0);

        // Address wraps from top word to word 0
        ed[0] = 32'hCAFEF00D; ed[1] = 32'h00000001;
        read_burst(4'd9, 32'h3FFC, 4'd1, INCR, OKAY, 1'b0);

        // Reserved burst type: SLVERR, memory untouched
        wd[0] = 32'hFFFFFFFF; wd[1] = 32'hFFFFFFFF;
        write_burst(4'd6, 32'h0, 4'd1, RSVD, SLVERR);
        ed[0] = 32'h00000001;
        read_burst(4'd6, 32'h0, 4'd0, RSVD, SLVERR, 1'b0);

        // W ahead of AW must stall
        @(posedge aclk); #1;
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("w_before_aw_stall", 32'(wready), 32'd0);
        end
        @(posedge aclk); #1;
        wvalid = 1'b0;

        // Simultaneous AR and AW handshakes
        wd[0] = 32'h55555555; wd[1] = 32'h66666666;
        ed[0] = 32'hDEADBE11;
        fork
            write_burst(4'd12, 32'h400, 4'd1, INCR, OKAY);
            read_burst(4'd13, 32'h100, 4'd0, INCR, OKAY, 1'b0);
        join
        ed[0] = 32'h55555555; ed[1] = 32'h66666666;
        read_burst(4'd14, 32'h400, 4'd1, INCR, OKAY, 1'b0);

        // Reset asserted during the second R beat of a burst
        @(posedge aclk); #1;
        arid = 4'd5; araddr = 32'h0; arlen = 4'd3; arburst = INCR; arvalid = 1'b1;
        n = 0; @(negedge aclk);
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0; @(negedge aclk);
        while (!rvalid && n < 50) begin @(negedge aclk); n++; end
        check("rst_seq_beat1", rdata, 32'd1);
        @(posedge aclk); #1;
        check("rst_seq_beat2_valid", 32'(rvalid), 32'd1);
        check("rst_seq_beat2", rdata, 32'd2);
        aresetn = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_arready", 32'(arready), 32'd0);
        rready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        check("rst_release_arready", 32'(arready), 32'd0);
        @(posedge aclk); #1;
        check("rst_release_arready_1cyc", 32'(arready), 32'd1);
        rready = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("rst_no_more_beats", 32'(rvalid), 32'd0);
        end
        rready = 1'b0;

        // Memory survives reset
        ed[0] = 32'hDEADBE11;
        read_burst(4'd1, 32'h100, 4'd0, INCR, OKAY, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
